// File: rtl/uart_tx_mmio_pkg.sv
// Shared types and constants for the memory-mapped UART transmitter.
// Frame layout is 8N1: one start bit, eight data bits LSB first, one stop bit.
package uart_tx_mmio_pkg;

  typedef enum logic [1:0] {
    UART_STATE_IDLE  = 2'd0,
    UART_STATE_START = 2'd1,
    UART_STATE_DATA  = 2'd2,
    UART_STATE_STOP  = 2'd3
  } uart_state_e;

  localparam int         UART_FRAME_BITS = 10;
  localparam int         UART_DATA_BITS  = UART_FRAME_BITS - 2;
  localparam logic [2:0] UART_LAST_BIT   = 3'(UART_DATA_BITS - 1);

endpackage

// File: rtl/uart_tx_mmio_sync_fifo.sv
// Synchronous FIFO with occupancy count; pushes to a full FIFO and pops from an
// empty one are ignored. Storage is not reset, only pointers and count are.
module uart_tx_mmio_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_wr_data,
  output logic [WIDTH-1:0]         o_rd_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_rd_data = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wr_data;
  end

  // Pointers are exactly log2(DEPTH) bits, so they wrap modulo DEPTH for free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped byte port to 8N1 UART transmitter. Store-byte strobes land in a
// FIFO; a write hitting a full FIFO raises clk_stall until a slot frees.
module uart_tx_mmio
  import uart_tx_mmio_pkg::*;
#(
  parameter int CLOCKS_PER_BIT = 104,
  parameter int FIFO_DEPTH     = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          write_enabled,
  input  logic [7:0]                    write_value,
  output logic                          clk_stall,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy,
  output logic                          tx
);
  localparam int BW = $clog2(CLOCKS_PER_BIT);

  uart_state_e  r_state;
  uart_state_e  w_next_state;
  logic [BW-1:0] r_baud;
  logic [2:0]   r_bit;
  logic [7:0]   r_shift;
  logic         r_tx;
  logic         w_tx_next;
  logic         w_baud_done;
  logic         w_pop;
  logic         w_full;
  logic         w_empty;
  logic [7:0]   w_head;

  uart_tx_mmio_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_push    (write_enabled),
    .i_pop     (w_pop),
    .i_wr_data (write_value),
    .o_rd_data (w_head),
    .o_count   (fifo_count),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  // Full is taken from the registered count, so a pop on the same edge never
  // admits a push into a full FIFO; the writer simply stalls one more cycle.
  assign clk_stall   = write_enabled && w_full;
  assign w_baud_done = (r_baud == BW'(CLOCKS_PER_BIT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= UART_STATE_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    unique case (r_state)
      UART_STATE_IDLE: begin
        if (!w_empty) begin
          w_next_state = UART_STATE_START;
          w_pop        = 1'b1;
        end
      end
      UART_STATE_START: if (w_baud_done) w_next_state = UART_STATE_DATA;
      UART_STATE_DATA:  if (w_baud_done && r_bit == UART_LAST_BIT) w_next_state = UART_STATE_STOP;
      UART_STATE_STOP: begin
        if (w_baud_done) begin
          if (!w_empty) begin
            w_next_state = UART_STATE_START;
            w_pop        = 1'b1;
          end else begin
            w_next_state = UART_STATE_IDLE;
          end
        end
      end
    endcase
  end

  // Next line level: low when a frame is launched, next data bit at each bit
  // boundary, high once the last data bit has been on the line.
  always_comb begin
    w_tx_next = r_tx;
    unique case (r_state)
      UART_STATE_IDLE:  w_tx_next = !w_pop;
      UART_STATE_START: if (w_baud_done) w_tx_next = r_shift[0];
      UART_STATE_DATA:  if (w_baud_done) w_tx_next = (r_bit == UART_LAST_BIT) ? 1'b1 : r_shift[1];
      UART_STATE_STOP:  if (w_baud_done) w_tx_next = !w_pop;
    endcase
  end

  assign busy = (r_state != UART_STATE_IDLE);
  assign tx   = r_tx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx   <= 1'b1;
      r_baud <= '0;
      r_bit  <= '0;
    end else begin
      r_tx <= w_tx_next;
      if (r_state == UART_STATE_IDLE || w_baud_done) r_baud <= '0;
      else                                           r_baud <= r_baud + 1'b1;
      if (r_state == UART_STATE_START && w_baud_done)     r_bit <= '0;
      else if (r_state == UART_STATE_DATA && w_baud_done) r_bit <= r_bit + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_pop)                                          r_shift <= w_head;
    else if (r_state == UART_STATE_DATA && w_baud_done) r_shift <= {1'b0, r_shift[7:1]};
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Bench for uart_tx_mmio: cycle-exact frame tables, directed corner sequences,
// and a random byte stream decoded by an independent UART receiver.
module tb_uart_tx_mmio;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       write_enabled = 1'b0;
  logic [7:0] write_value = 8'h00;
  logic       clk_stall;
  logic [2:0] fifo_count;
  logic       busy;
  logic       tx;

  uart_tx_mmio #(
    .CLOCKS_PER_BIT (CPB),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .write_enabled (write_enabled),
    .write_value   (write_value),
    .clk_stall     (clk_stall),
    .fifo_count    (fifo_count),
    .busy          (busy),
    .tx            (tx)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  int rx_start_q[$];
  int cyc = 0;
  int max_cnt = 0;

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;  // frame[k] = line level during bit k (k=0 start, k=9 stop)
  } vec_t;
  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_now(input logic [7:0] b);
    write_enabled = 1'b1;
    write_value   = b;
    @(posedge clk);
    #1;
    write_enabled = 1'b0;
    exp_q.push_back(b);
  endtask

  task automatic push_held(input logic [7:0] b, output int sc);
    write_enabled = 1'b1;
    write_value   = b;
    sc = 0;
    #1;
    while (clk_stall && sc < 5000) begin
      sc++;
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    write_enabled = 1'b0;
    exp_q.push_back(b);
  endtask

  task automatic wait_compare(input string name);
    int budget;
    int g;
    budget = (exp_q.size() + 2) * FRAME * 2;
    g = 0;
    while (rx_q.size() < exp_q.size() && g < budget) begin
      tick(1);
      g++;
    end
    tick(4);
    check({name, "_count"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < rx_q.size()) check({name, "_byte"}, rx_q[i], exp_q[i]);
    exp_q.delete();
    rx_q.delete();
  endtask

  // Independent receiver: detect the falling start edge, sample mid-bit.
  initial begin : rx_model
    bit         active;
    int         k;
    logic [7:0] sh;
    active = 1'b0;
    k = 0;
    sh = 8'h00;
    forever begin
      @(posedge clk);
      #3;
      cyc++;
      if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
      if (rst) begin
        active = 1'b0;
      end else begin
        if (!active && tx === 1'b0) begin
          active = 1'b1;
          k = 0;
          rx_start_q.push_back(cyc);
        end
        if (active) begin
          if (k == CPB / 2) check("rx_start_bit", tx, 0);
          else if (k % CPB == CPB / 2 && k < 9 * CPB) sh = {tx, sh[7:1]};
          else if (k == 9 * CPB + CPB / 2) begin
            check("rx_stop_bit", tx, 1);
            rx_q.push_back(sh);
            active = 1'b0;
          end
          k++;
        end
      end
    end
  end

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1);
  end

  initial begin : main
    int sc;
    int stall_cycles;
    int stall_total;
    logic [7:0] b;

    vecs[0] = '{8'hA5, 10'b1_10100101_0};
    vecs[1] = '{8'h00, 10'b1_00000000_0};
    vecs[2] = '{8'hFF, 10'b1_11111111_0};
    vecs[3] = '{8'h3C, 10'b1_00111100_0};
    vecs[4] = '{8'h81, 10'b1_10000001_0};

    #1 rst = 1'b1;
    tick(3);
    check("reset_tx", tx, 1);
    check("reset_busy", busy, 0);
    check("reset_count", fifo_count, 0);
    check("reset_stall", clk_stall, 0);
    rst = 1'b0;
    tick(2);

    // Cycle-exact frames for single bytes into an idle block.
    foreach (vecs[v]) begin
      push_now(vecs[v].data);
      check("tbl_count_push", fifo_count, 1);
      check("tbl_tx_idle", tx, 1);
      check("tbl_busy_idle", busy, 0);
      for (int k = 0; k < FRAME; k++) begin
        tick(1);
        check("tbl_tx", tx, vecs[v].frame[k / CPB]);
        check("tbl_busy", busy, 1);
        if (k == 0) check("tbl_count_pop", fifo_count, 0);
      end
      tick(1);
      check("tbl_tx_end", tx, 1);
      check("tbl_busy_end", busy, 0);
      wait_compare("tbl_rx");
    end

    // Three consecutive pushes: back-to-back frames, count peaks at 2.
    max_cnt = 0;
    rx_start_q.delete();
    push_now(8'h01);
    push_now(8'h02);
    push_now(8'h03);
    wait_compare("b2b_rx");
    check("b2b_max_count", max_cnt, 2);
    check("b2b_frames", rx_start_q.size(), 3);
    if (rx_start_q.size() >= 3) begin
      check("b2b_gap1", rx_start_q[1] - rx_start_q[0], FRAME);
      check("b2b_gap2", rx_start_q[2] - rx_start_q[1], FRAME);
    end

    // One byte on the line plus four buffered; the sixth write must stall.
    for (int i = 0; i < 5; i++) push_now(8'h10 + 8'(i));
    check("fill_count", fifo_count, 4);
    write_enabled = 1'b1;
    write_value   = 8'h15;
    stall_cycles  = 0;
    forever begin
      #1;
      if (!clk_stall || stall_cycles >= 200) break;
      stall_cycles++;
      @(posedge clk);
    end
    check("fill_stall_cycles", stall_cycles, FRAME - 3);
    check("fill_count_after_pop", fifo_count, 3);
    @(posedge clk);
    #1;
    write_enabled = 1'b0;
    exp_q.push_back(8'h15);
    check("fill_count_landed", fifo_count, 4);
    wait_compare("fill_rx");

    // Asynchronous reset during data bit 3 of 0x55.
    push_now(8'h55);
    push_now(8'h66);
    tick(16);
    check("rst_pre_tx", tx, 0);
    check("rst_pre_busy", busy, 1);
    check("rst_pre_count", fifo_count, 1);
    tick(1);
    rst = 1'b1;
    #1;
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_count", fifo_count, 0);
    tick(2);
    rst = 1'b0;
    exp_q.delete();
    rx_q.delete();
    tick(2);
    push_now(8'hFF);
    wait_compare("rst_post_rx");

    // Push lands on the stop-bit terminal edge with the FIFO empty.
    push_now(8'h3C);
    tick(FRAME);
    check("stopedge_busy_pre", busy, 1);
    check("stopedge_count_pre", fifo_count, 0);
    push_now(8'hC3);
    check("stopedge_count", fifo_count, 1);
    check("stopedge_idle", busy, 0);
    check("stopedge_tx_idle", tx, 1);
    tick(1);
    check("stopedge_busy_start", busy, 1);
    check("stopedge_tx_start", tx, 0);
    check("stopedge_count_pop", fifo_count, 0);
    wait_compare("stopedge_rx");

    // Random stream with held writes under stall.
    max_cnt = 0;
    stall_total = 0;
    for (int i = 0; i < 200; i++) begin
      b = 8'($urandom);
      push_held(b, sc);
      stall_total += sc;
      if ($urandom_range(0, 9) == 0) tick($urandom_range(1, 60));
    end
    wait_compare("rand_rx");
    check("rand_max_count_le_depth", max_cnt <= DEPTH, 1);
    check("rand_stall_seen", stall_total > 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
